// File: rtl/scc_fetch_unit.sv
// scc_fetch_unit: instruction-fetch stage of the SCC.
// It owns the PC and drives the memory fetch port. Fetched words go into a
// small FIFO that feeds decode over a valid/ready handshake. The unit also
// handles branch redirects and raises the halt level.
//
// Handshake: a head word transfers to decode on every rising Clk edge where
//   inst_valid=1 and decode_ready=1. While inst_valid=1 and decode_ready=0,
//   inst_out and inst_pc hold their values. A flush (redirect or halt) has
//   priority, and any pop in that same cycle is dropped.
//
// instruction_memory_a always shows the address currently being fetched.
// When a word is pushed, the address moves on to the next word immediately.
// If that push fills the queue, the unit parks in STALL with the new address
// already presented. It restarts the wait counter once a slot frees up.
module scc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_LAT  = 1,
   parameter int          QDEPTH   = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic        instruction_memory_en,
   output logic [31:0] instruction_memory_a,
   input  logic [31:0] instruction_memory_v,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        decode_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_in,
   output logic        halt_f,
   output logic [1:0]  dbg_state
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
   localparam logic [PW:0]   Q_FULL   = (PW+1)'(QDEPTH);
   localparam logic [PW+1:0] Q_FULL_W = (PW+2)'(QDEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_STALL  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          en_q, en_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          halt_q, halt_d;

   logic [31:0]   qd_q [QDEPTH];
   logic [31:0]   qp_q [QDEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [PW:0]   count_q, count_d;
   logic          valid_q;

   logic          active, halt_take, redir_take, flush;
   logic          fetch_done, push, pop;
   logic [PW+1:0] occ_after;

   // Event decode. The priority is halt, then redirect, then normal fetch.
   always_comb begin
      active     = (state_q == S_FETCH) || (state_q == S_STALL);
      halt_take  = active && halt_in;
      redir_take = active && redirect_valid && !halt_in;
      flush      = halt_take || redir_take;
      fetch_done = (state_q == S_FETCH) && (cnt_q == '0);
      push       = fetch_done && !flush;
      pop        = valid_q && decode_ready && !flush;
      occ_after  = {1'b0, count_q} + (PW+2)'(fetch_done)
                   - (PW+2)'(valid_q && decode_ready);
   end

   // Next-state logic for the fetch FSM, the PC/address, the wait counter and halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            en_d    = 1'b1;
            cnt_d   = CNT_INIT;
         end
         S_FETCH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               pc_d  = pc_q + 32'd4;
               cnt_d = CNT_INIT;
               if (occ_after >= Q_FULL_W) state_d = S_STALL;
            end
         end
         S_STALL: begin
            if (count_q < Q_FULL) begin
               state_d = S_FETCH;
               cnt_d   = CNT_INIT;
            end
         end
         default: ;
      endcase
      if (redir_take) begin
         pc_d    = redirect_pc & 32'hFFFF_FFFC;
         cnt_d   = CNT_INIT;
         state_d = S_FETCH;
      end
      if (halt_take) begin
         state_d = S_HALTED;
         en_d    = 1'b0;
         halt_d  = 1'b1;
         pc_d    = pc_q;
         cnt_d   = cnt_q;
      end
   end

   // Queue occupancy next value. A flush empties the queue.
   always_comb begin
      if (flush) count_d = '0;
      else       count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   // Control registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         en_q    <= 1'b0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
      end
   end

   // Instruction FIFO. A pushed word becomes visible at the head the next cycle.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) begin
            qd_q[i] <= '0;
            qp_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         valid_q <= (count_d != '0);
         if (flush) begin
            rd_q <= '0;
            wr_q <= '0;
         end else begin
            if (push) begin
               qd_q[wr_q] <= instruction_memory_v;
               qp_q[wr_q] <= pc_q;
               wr_q       <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
         end
      end
   end

   assign instruction_memory_en = en_q;
   assign instruction_memory_a  = pc_q;
   assign inst_valid            = valid_q;
   assign inst_out              = qd_q[rd_q];
   assign inst_pc               = qp_q[rd_q];
   assign halt_f                = halt_q;
   assign dbg_state             = state_q;

endmodule
